led_ctrl: RTL and testbench

Parametrised multi-channel LED driver that replaces the direct clock-to-pin LED connection with per-channel registered outputs. Each channel is configured at run time as off, on, blinking at a programmable period, or PWM-dimmed at a programmable duty cycle. The block sits between the board-level control logic, which writes the configuration, and the LED pins.

---
 rtl/led_pkg.sv | 11 +
 rtl/led_chan.sv | 86 ++++++++
 rtl/led_ctrl.sv | 66 ++++++
 tb/tb_led_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode encoding for the LED driver
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_t;

endpackage

// File: rtl/led_chan.sv
// rtl/led_chan.sv - one LED channel: config registers, blink timer, registered drive
module led_chan
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int BLINK_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [1:0]          mode_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [BLINK_W-1:0]  period_i,
  input  logic                tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o
);

  localparam logic [BLINK_W-1:0] ONE = BLINK_W'(1);

  led_mode_t           mode_q, mode_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [BLINK_W-1:0]  period_q, period_d;
  logic [BLINK_W-1:0]  cnt_q, cnt_d;
  logic [BLINK_W-1:0]  eff_period;
  logic                phase_q, phase_d;
  logic                led_q, led_d;

  // A zero period behaves as one tick per half-period.
  assign eff_period = (period_q == '0) ? ONE : period_q;

  // A write outranks a coincident tick: the timer restarts high.
  always_comb begin
    mode_d   = mode_q;
    duty_d   = duty_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    if (we_i) begin
      mode_d   = led_mode_t'(mode_i);
      duty_d   = duty_i;
      period_d = period_i;
      cnt_d    = '0;
      phase_d  = 1'b1;
    end else if (tick_i && (mode_q == LED_BLINK)) begin
      if (cnt_q == (eff_period - ONE)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      LED_OFF:   led_d = 1'b0;
      LED_ON:    led_d = 1'b1;
      LED_BLINK: led_d = phase_q;
      LED_PWM:   led_d = (pwm_cnt_i < duty_q);
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= LED_OFF;
      duty_q   <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - multi-channel LED driver: prescaler, shared PWM counter, write decode
module led_ctrl
  import led_pkg::*;
#(
  parameter int  CH       = 4,
  parameter int  PRESCALE = 50000,
  parameter int  PWM_BITS = 8,
  parameter int  BLINK_W  = 16,
  localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  input  logic [BLINK_W-1:0]  cfg_period,
  output logic [CH-1:0]       led
);

  localparam int PRESC_W = $clog2(PRESCALE);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick;
  logic                ch_valid;

  assign tick     = (presc_q == PRESC_W'(PRESCALE - 1));
  assign ch_valid = (int'(cfg_ch) < CH);

  always_comb begin
    presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    logic we;
    assign we = cfg_we && ch_valid && (cfg_ch == CH_W'(g));

    led_chan #(
      .PWM_BITS(PWM_BITS),
      .BLINK_W (BLINK_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (we),
      .mode_i   (cfg_mode),
      .duty_i   (cfg_duty),
      .period_i (cfg_period),
      .tick_i   (tick),
      .pwm_cnt_i(pwm_cnt_q),
      .led_o    (led[g])
    );
  end

endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - self-checking bench for led_ctrl against a tick-counting reference model
module tb_led_ctrl;

  localparam int CH = 3;
  localparam int P  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_duty = '0;
  logic [15:0] cfg_period = '0;
  logic [2:0]  led;

  int errors = 0;
  int checks = 0;
  int k = 0;
  int m_mode[CH];
  int m_duty[CH];
  int m_eff[CH];
  int m_ticks[CH];

  led_ctrl #(.CH(CH), .PRESCALE(P), .PWM_BITS(8), .BLINK_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_duty  (cfg_duty),
    .cfg_period(cfg_period),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = 0; m_duty[i] = 0; m_eff[i] = 1; m_ticks[i] = 0;
    end
    k = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_async", int'(led), 0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_hold", int'(led), 0);
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: drive inputs, predict the registered led from the pre-edge model, then advance the model.
  task automatic cyc(input logic we, input int ch, input int mode, input int duty, input int period);
    int exp;
    cfg_we = we; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
    cfg_duty = 8'(duty); cfg_period = 16'(period);
    @(posedge clk);
    k++;
    exp = 0;
    for (int i = 0; i < CH; i++) begin
      case (m_mode[i])
        1: exp |= (1 << i);
        2: if (((m_ticks[i] / m_eff[i]) % 2) == 0) exp |= (1 << i);
        3: if (((k - 1) % 256) < m_duty[i]) exp |= (1 << i);
        default: ;
      endcase
    end
    for (int i = 0; i < CH; i++) begin
      if (we && ch == i) begin
        m_mode[i] = mode; m_duty[i] = duty;
        m_eff[i] = (period == 0) ? 1 : period;
        m_ticks[i] = 0;
      end else if ((k % P) == 0 && m_mode[i] == 2) begin
        m_ticks[i]++;
      end
    end
    #1;
    chk("led", int'(led), exp);
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0);
  endtask

  task automatic pwm_window(input int duty);
    int hi;
    cyc(1'b1, 1, 3, duty, 0);
    idle(2);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 0, 0, 0, 0);
      hi += int'(led[1]);
    end
    chk("pwm_hi", hi, duty);
  endtask

  initial begin
    #2;
    do_reset();
    idle(6);

    cyc(1'b1, 2, 1, 0, 0);
    idle(1);
    chk("on_ch2", int'(led), 3'b100);
    idle(2);
    cyc(1'b1, 2, 0, 0, 0);
    idle(3);
    chk("off_ch2", int'(led), 0);

    cyc(1'b1, 0, 2, 0, 3);
    idle(80);
    cyc(1'b1, 0, 2, 0, 0);
    idle(24);

    pwm_window(64);
    pwm_window(0);
    pwm_window(255);
    cyc(1'b1, 1, 0, 0, 0);

    cyc(1'b1, 2, 1, 0, 0);
    idle(3);
    cyc(1'b1, 3, 0, 200, 7);
    cyc(1'b1, 3, 2, 9, 1);
    idle(6);
    chk("invalid_ch", int'(led), 3'b100);

    cyc(1'b1, 0, 2, 0, 2);
    idle(5);
    while (((k + 1) % P) != 0) idle(1);
    cyc(1'b1, 0, 2, 0, 2);
    idle(30);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0)
        cyc(1'b1, int'($urandom_range(3)), int'($urandom_range(3)),
            int'($urandom_range(255)), int'($urandom_range(4)));
      else
        idle(1);
    end

    cyc(1'b1, 2, 1, 0, 0);
    idle(3);
    do_reset();
    idle(12);
    cyc(1'b1, 0, 2, 0, 1);
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
